// File: rtl/dffa_if.sv
// Data-side bundle for a dffa instance: d toward the register, q (and qn) back.
// qn exists only when DFFA_QN_EN is defined, matching the register's port list.
interface dffa_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
`ifdef DFFA_QN_EN
  logic [WIDTH-1:0] qn;

  modport master (output d, input q, input qn);
  modport slave  (input d, output q, output qn);
`else
  modport master (output d, input q);
  modport slave  (input d, output q);
`endif
endinterface

// File: rtl/dffa.sv
// dffa: WIDTH-bit rising-edge register with async active-high reset to RST_VAL; latency 1 clk, no backpressure.
// Define DFFA_QN_EN to add output qn (always ~q); positional port order is (d, clk, q, rst[, qn]).
module dffa #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  output logic [WIDTH-1:0] q,
  input  logic             rst
`ifdef DFFA_QN_EN
  ,
  output logic [WIDTH-1:0] qn
`endif
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign q_d = d;

  // Reset takes priority on every edge, so clocks during reset and a release
  // coincident with a rising clk both leave q at RST_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

`ifdef DFFA_QN_EN
  assign qn = ~q_q;
`endif

endmodule

// File: tb/tb_dffa.sv
// Bench for dffa: a 1-bit instance (RST_VAL 0) and an 8-bit instance (RST_VAL 8'hA5) share clk/rst.
// Clock period 20 ns from t=0; d changes only on falling edges.
module tb_dffa;

  typedef struct {
    logic       d1;
    logic [7:0] d8;
    logic       q1;
    logic [7:0] q8;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  dffa_if #(.WIDTH(1)) bus1 ();
  dffa_if #(.WIDTH(8)) bus8 ();

  dffa #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
    .d   (bus1.d),
    .clk (clk),
    .q   (bus1.q),
    .rst (rst)
`ifdef DFFA_QN_EN
    ,
    .qn  (bus1.qn)
`endif
  );

  dffa #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
    .d   (bus8.d),
    .clk (clk),
    .q   (bus8.q),
    .rst (rst)
`ifdef DFFA_QN_EN
    ,
    .qn  (bus8.qn)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic exp1, input logic [7:0] exp8);
    check({name, "_q1"}, {7'd0, bus1.q}, {7'd0, exp1});
    check({name, "_q8"}, bus8.q, exp8);
`ifdef DFFA_QN_EN
    check({name, "_qn1"}, {7'd0, bus1.qn}, {7'd0, ~exp1});
    check({name, "_qn8"}, bus8.qn, ~exp8);
`endif
  endtask

  vec_t vecs [10];
  vec_t sb [$];
  vec_t got;
  logic       last_q1;
  logic [7:0] last_q8;

  initial begin
    total = 0;
    bad   = 0;

    // Release phase: each record is driven at a falling edge, its expected
    // output is popped after the following rising edge.
    vecs[0] = '{1'b0, 8'h3C, 1'b0, 8'h3C};
    vecs[1] = '{1'b1, 8'hC3, 1'b1, 8'hC3};
    vecs[2] = '{1'b0, 8'hFF, 1'b0, 8'hFF};
    vecs[3] = '{1'b1, 8'h00, 1'b1, 8'h00};
    vecs[4] = '{1'b0, 8'h5A, 1'b0, 8'h5A};
    vecs[5] = '{1'b1, 8'hA5, 1'b1, 8'hA5};
    vecs[6] = '{1'b0, 8'h01, 1'b0, 8'h01};
    vecs[7] = '{1'b1, 8'h80, 1'b1, 8'h80};
    vecs[8] = '{1'b0, 8'h7E, 1'b0, 8'h7E};
    vecs[9] = '{1'b1, 8'h3C, 1'b1, 8'h3C};

    rst    = 1'b1;
    bus1.d = 1'b0;
    bus8.d = 8'h00;

    // Reset hold 0..800 ns with d toggling: outputs pinned at reset value.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      check_outs("rst_hold_pos", 1'b0, 8'hA5);
      if (i < 39) begin
        @(negedge clk);
        bus1.d = ~bus1.d;
        bus8.d = bus8.d + 8'h11;
        #1;
        check_outs("rst_hold_neg", 1'b0, 8'hA5);
      end
    end

    last_q1 = 1'b0;
    last_q8 = 8'hA5;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) rst = 1'b0;
      bus1.d = vecs[k].d1;
      bus8.d = vecs[k].d8;
      sb.push_back(vecs[k]);
      #1;
      check_outs("no_change_neg", last_q1, last_q8);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty at %0t: got size 0 want >0", $time);
      end else begin
        got = sb.pop_front();
        check_outs("load", got.q1, got.q8);
        last_q1 = got.q1;
        last_q8 = got.q8;
      end
    end

    // Async assert midway between edges with q1 == 1.
    #4;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 1'b0, 8'hA5);

    @(negedge clk);
    bus1.d = 1'b1;
    bus8.d = 8'h3C;
    @(posedge clk);
    #1;
    check_outs("rst_clk_ignored", 1'b0, 8'hA5);

    // Release coincident with a rising edge: reset must win on that edge.
    @(posedge clk);
    rst <= 1'b0;
    #1;
    check_outs("simul_edge", 1'b0, 8'hA5);
    @(posedge clk);
    #1;
    check_outs("first_load", 1'b1, 8'h3C);
    check("sb_drained", 8'(sb.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
